// File: rtl/hd44780_nybbler_if.sv
// ---------------------------------------------------------------------------
// hd44780_nybbler_if
// Request/acknowledge bus between an upstream LCD controller and the
// hd44780_nybbler byte-to-nybble transmitter.
//
// Signals:
//   STB_I   request strobe from the upstream controller
//   DAT_I   byte to send
//   RS_I    register select (0 = command, 1 = data)
//   NYB_I   send DAT_I[7:4] only (init sequences)
//   ACK_O   one-cycle accept pulse from the nybbler
//   BUSY_O  transfer or post-transfer wait in progress
//
// Modports: master = upstream controller, slave = nybbler.
// ---------------------------------------------------------------------------
interface hd44780_nybbler_if;
   logic       STB_I;
   logic [7:0] DAT_I;
   logic       RS_I;
   logic       NYB_I;
   logic       ACK_O;
   logic       BUSY_O;

   modport master (output STB_I, DAT_I, RS_I, NYB_I, input ACK_O, BUSY_O);
   modport slave  (input STB_I, DAT_I, RS_I, NYB_I, output ACK_O, BUSY_O);
endinterface

// File: rtl/hd44780_nybbler.sv
// ---------------------------------------------------------------------------
// hd44780_nybbler
// Sends one byte (or one high nybble) to an HD44780 LCD over its 4-bit bus,
// with exact setup / enable / gap timing, then holds BUSY for the settling
// time the controller needs (long for clear/home, short otherwise).
//
// Ports:
//   CLK_I   clock (single domain)
//   RST_I   synchronous active-high reset
//   bus     request/ack bus (slave side): STB_I, DAT_I, RS_I, NYB_I in;
//           ACK_O, BUSY_O out
//   LCD_E   HD44780 enable
//   LCD_RS  HD44780 register select
//   LCD_RW  HD44780 read/write, tied to write
//   LCD_D   HD44780 DB7..DB4
// All outputs are registered.
// ---------------------------------------------------------------------------
module hd44780_nybbler #(
   parameter int SETUP_CYCLES     = 2,
   parameter int E_PULSE_CYCLES   = 24,
   parameter int GAP_CYCLES       = 48,
   parameter int CMD_WAIT_CYCLES  = 2000,
   parameter int LONG_WAIT_CYCLES = 80000
) (
   input  logic                 CLK_I,
   input  logic                 RST_I,
   hd44780_nybbler_if.slave     bus,
   output logic                 LCD_E,
   output logic                 LCD_RS,
   output logic                 LCD_RW,
   output logic [3:0]           LCD_D
);

   localparam int MAX_A   = (SETUP_CYCLES > E_PULSE_CYCLES) ? SETUP_CYCLES : E_PULSE_CYCLES;
   localparam int MAX_B   = (GAP_CYCLES > CMD_WAIT_CYCLES) ? GAP_CYCLES : CMD_WAIT_CYCLES;
   localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_CYC = (MAX_C > LONG_WAIT_CYCLES) ? MAX_C : LONG_WAIT_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);

   // Counter reload values: a state lasting N cycles counts N-1 down to 0.
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] E_LD     = CW'(E_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, HI_SETUP, HI_E, HI_GAP, LO_SETUP, LO_E, LO_GAP, WAIT
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          accept;
   logic          rs_n;
   logic [3:0]    d_n;
   logic          ack_q, busy_q;

   logic [7:0]    dat_q;
   logic          rs_q, nyb_q;
   logic          long_cmd;
   logic [CW-1:0] wait_ld;

   // Clear display (0x01) and return home (0x02/0x03) need the long settle.
   assign long_cmd = !rs_q && !nyb_q &&
                     ((dat_q == 8'h01) || (dat_q == 8'h02) || (dat_q == 8'h03));
   assign wait_ld  = long_cmd ? LONG_LD : CMD_LD;

   assign bus.ACK_O  = ack_q;
   assign bus.BUSY_O = busy_q;
   assign LCD_RW     = 1'b0;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      rs_n    = LCD_RS;
      d_n     = LCD_D;
      case (state)
         IDLE: begin
            if (bus.STB_I) begin
               accept  = 1'b1;
               state_n = HI_SETUP;
               cnt_n   = SETUP_LD;
               rs_n    = bus.RS_I;
               d_n     = bus.DAT_I[7:4];
            end
         end
         HI_SETUP: begin
            if (cnt == '0) begin
               state_n = HI_E;
               cnt_n   = E_LD;
            end else cnt_n = cnt - 1'b1;
         end
         HI_E: begin
            if (cnt == '0) begin
               state_n = HI_GAP;
               cnt_n   = GAP_LD;
            end else cnt_n = cnt - 1'b1;
         end
         HI_GAP: begin
            if (cnt == '0) begin
               if (nyb_q) begin
                  state_n = WAIT;
                  cnt_n   = wait_ld;
               end else begin
                  state_n = LO_SETUP;
                  cnt_n   = SETUP_LD;
                  d_n     = dat_q[3:0];
               end
            end else cnt_n = cnt - 1'b1;
         end
         LO_SETUP: begin
            if (cnt == '0) begin
               state_n = LO_E;
               cnt_n   = E_LD;
            end else cnt_n = cnt - 1'b1;
         end
         LO_E: begin
            if (cnt == '0) begin
               state_n = LO_GAP;
               cnt_n   = GAP_LD;
            end else cnt_n = cnt - 1'b1;
         end
         LO_GAP: begin
            if (cnt == '0) begin
               state_n = WAIT;
               cnt_n   = wait_ld;
            end else cnt_n = cnt - 1'b1;
         end
         WAIT: begin
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - 1'b1;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state decode, so LCD_E is a clean
   // flop output and every output lines up with the state it belongs to.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state  <= IDLE;
         cnt    <= '0;
         ack_q  <= 1'b0;
         busy_q <= 1'b0;
         LCD_E  <= 1'b0;
         LCD_RS <= 1'b0;
         LCD_D  <= 4'h0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         ack_q  <= accept;
         busy_q <= (state_n != IDLE);
         LCD_E  <= (state_n == HI_E) || (state_n == LO_E);
         LCD_RS <= rs_n;
         LCD_D  <= d_n;
      end
   end

   // Request fields captured at acceptance; no reset needed.
   always_ff @(posedge CLK_I) begin
      if (accept && !RST_I) begin
         dat_q <= bus.DAT_I;
         rs_q  <= bus.RS_I;
         nyb_q <= bus.NYB_I;
      end
   end

endmodule

// File: tb/tb_hd44780_nybbler.sv
// ---------------------------------------------------------------------------
// tb_hd44780_nybbler
// Directed bench for hd44780_nybbler with short timing parameters
// (setup 2, E pulse 4, gap 6, command wait 20, long wait 100).
// ---------------------------------------------------------------------------
module tb_hd44780_nybbler;

   localparam int S  = 2;
   localparam int EP = 4;
   localparam int G  = 6;

   logic       clk;
   logic       rst;
   logic       lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_d;

   int n_tests = 0;
   int n_fail  = 0;

   hd44780_nybbler_if bus ();

   hd44780_nybbler #(
      .SETUP_CYCLES     (S),
      .E_PULSE_CYCLES   (EP),
      .GAP_CYCLES       (G),
      .CMD_WAIT_CYCLES  (20),
      .LONG_WAIT_CYCLES (100)
   ) dut (
      .CLK_I  (clk),
      .RST_I  (rst),
      .bus    (bus.slave),
      .LCD_E  (lcd_e),
      .LCD_RS (lcd_rs),
      .LCD_RW (lcd_rw),
      .LCD_D  (lcd_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (bus.BUSY_O !== 1'b0 && guard < 300) begin
         step();
         guard++;
      end
      if (guard >= 300) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_idle: BUSY_O=%b required 0 within 300 cycles", bus.BUSY_O);
      end
   endtask

   // Sends one request and checks every cycle from the ACK cycle (k=1) to
   // the first idle cycle. Expected waveform per cycle k:
   //   high nybble: setup k=1..2, E k=3..6, gap k=7..12
   //   low nybble:  setup k=13..14, E k=15..18, gap k=19..24, then wait
   // With poke set, a stray strobe with different fields is issued mid-transfer.
   task automatic run_xfer(input string name, input logic [7:0] b, input logic rs,
                           input logic nyb, input int exp_busy, input bit poke);
      int         busy_cnt = 0;
      logic       exp_e;
      logic [3:0] exp_d;
      logic [7:0] act, exp;
      bus.STB_I = 1'b1;
      bus.DAT_I = b;
      bus.RS_I  = rs;
      bus.NYB_I = nyb;
      step();
      bus.STB_I = 1'b0;
      for (int k = 1; k <= exp_busy + 1; k++) begin
         exp_e = (k >= S + 1 && k <= S + EP) ||
                 (!nyb && k >= 2*S + EP + G + 1 && k <= 2*(S + EP) + G);
         exp_d = (nyb || k <= S + EP + G) ? b[7:4] : b[3:0];
         act   = {bus.ACK_O, bus.BUSY_O, lcd_e, lcd_rs, lcd_d};
         exp   = {(k == 1), (k <= exp_busy), exp_e, rs, exp_d};
         if (bus.BUSY_O === 1'b1) busy_cnt++;
         n_tests++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: {ack,busy,e,rs,d}=%b required %b", name, k, act, exp);
         end
         if (poke && k == 5) begin
            bus.STB_I = 1'b1;
            bus.DAT_I = ~b;
            bus.RS_I  = ~rs;
            bus.NYB_I = ~nyb;
         end
         if (poke && k == 6) bus.STB_I = 1'b0;
         if (k <= exp_busy) step();
      end
      n_tests++;
      if (busy_cnt !== exp_busy) begin
         n_fail++;
         $display("FAIL %s busy_len: got %0d required %0d", name, busy_cnt, exp_busy);
      end
   endtask

   task automatic test_reset();
      bus.STB_I = 1'b0;
      bus.DAT_I = 8'h00;
      bus.RS_I  = 1'b0;
      bus.NYB_I = 1'b0;
      rst = 1'b1;
      step();
      step();
      n_tests++;
      if ({bus.ACK_O, bus.BUSY_O, lcd_e, lcd_rs, lcd_rw, lcd_d} !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_state: {ack,busy,e,rs,rw,d}=%b required 000000000",
                  {bus.ACK_O, bus.BUSY_O, lcd_e, lcd_rs, lcd_rw, lcd_d});
      end
      rst = 1'b0;
      step();
      n_tests++;
      if ({bus.ACK_O, bus.BUSY_O, lcd_e} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_release: {ack,busy,e}=%b required 000", {bus.ACK_O, bus.BUSY_O, lcd_e});
      end
   endtask

   task automatic test_data_byte();
      run_xfer("data_0x48", 8'h48, 1'b1, 1'b0, 44, 1'b0);
   endtask

   task automatic test_clear();
      wait_idle();
      run_xfer("clear_0x01", 8'h01, 1'b0, 1'b0, 124, 1'b0);
      wait_idle();
      run_xfer("home_0x02", 8'h02, 1'b0, 1'b0, 124, 1'b0);
      wait_idle();
      run_xfer("cmd_0x04", 8'h04, 1'b0, 1'b0, 44, 1'b0);
   endtask

   task automatic test_nybble();
      wait_idle();
      run_xfer("nybble_0x30", 8'h30, 1'b0, 1'b1, 32, 1'b0);
   endtask

   task automatic test_busy_ignore();
      wait_idle();
      run_xfer("busy_poke_0xA5", 8'hA5, 1'b1, 1'b0, 44, 1'b1);
   endtask

   task automatic test_back_to_back();
      int guard;
      int busy_cnt;
      wait_idle();
      bus.STB_I = 1'b1;
      bus.DAT_I = 8'h48;
      bus.RS_I  = 1'b1;
      bus.NYB_I = 1'b0;
      guard = 0;
      step();
      while (bus.ACK_O !== 1'b1 && guard < 10) begin
         step();
         guard++;
      end
      n_tests++;
      if (bus.ACK_O !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_ack: ACK_O=%b required 1", bus.ACK_O);
      end
      busy_cnt = 1;
      guard = 0;
      step();
      while (bus.BUSY_O === 1'b1 && guard < 200) begin
         busy_cnt++;
         step();
         guard++;
      end
      n_tests++;
      if (busy_cnt !== 44) begin
         n_fail++;
         $display("FAIL b2b_busy_len: got %0d required 44", busy_cnt);
      end
      n_tests++;
      if (bus.ACK_O !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle_cycle_ack: ACK_O=%b required 0", bus.ACK_O);
      end
      step();
      n_tests++;
      if ({bus.ACK_O, bus.BUSY_O, lcd_d} !== 6'b11_0100) begin
         n_fail++;
         $display("FAIL b2b_second_ack: {ack,busy,d}=%b required 110100", {bus.ACK_O, bus.BUSY_O, lcd_d});
      end
      bus.STB_I = 1'b0;
      step();
      n_tests++;
      if (bus.ACK_O !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_ack_width: ACK_O=%b required 0", bus.ACK_O);
      end
   endtask

   task automatic test_reset_mid();
      wait_idle();
      bus.STB_I = 1'b1;
      bus.DAT_I = 8'hC7;
      bus.RS_I  = 1'b1;
      bus.NYB_I = 1'b0;
      step();
      bus.STB_I = 1'b0;
      step();
      step();
      n_tests++;
      if ({lcd_e, lcd_d} !== 5'b1_1100) begin
         n_fail++;
         $display("FAIL rstmid_in_hi_e: {e,d}=%b required 11100", {lcd_e, lcd_d});
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++;
      if ({bus.BUSY_O, lcd_e, lcd_rs, lcd_d} !== 7'b0) begin
         n_fail++;
         $display("FAIL rstmid_after: {busy,e,rs,d}=%b required 0000000",
                  {bus.BUSY_O, lcd_e, lcd_rs, lcd_d});
      end
      run_xfer("after_reset_0x30", 8'h30, 1'b0, 1'b1, 32, 1'b0);
   endtask

   task automatic test_reset_priority();
      wait_idle();
      rst       = 1'b1;
      bus.STB_I = 1'b1;
      bus.DAT_I = 8'h55;
      bus.RS_I  = 1'b1;
      bus.NYB_I = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         n_tests++;
         if ({bus.ACK_O, bus.BUSY_O, lcd_e} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_priority_%0d: {ack,busy,e}=%b required 000", i, {bus.ACK_O, bus.BUSY_O, lcd_e});
         end
      end
      bus.STB_I = 1'b0;
      rst       = 1'b0;
      step();
      n_tests++;
      if ({bus.ACK_O, bus.BUSY_O} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_priority_release: {ack,busy}=%b required 00", {bus.ACK_O, bus.BUSY_O});
      end
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_data_byte();
      test_clear();
      test_nybble();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_reset_priority();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hd44780_nybbler.md
HD44780_NYBBLER -- requirements
Module: hd44780_nybbler

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: cycles RS/data are stable before E rises.
REQ-002 SHALL have parameter E_PULSE_CYCLES, default 24: E high width (500 ns at 48 MHz).
REQ-003 SHALL have parameter GAP_CYCLES, default 48: E low time after each nybble, before the next phase.
REQ-004 SHALL have parameter CMD_WAIT_CYCLES, default 2000: post-transfer wait for ordinary commands and data.
REQ-005 SHALL have parameter LONG_WAIT_CYCLES, default 80000: post-transfer wait for clear/home.
REQ-006 SHALL have port CLK_I, input, 1 bit: single clock; one clock domain; reset is synchronous and active-high.
REQ-007 SHALL have port RST_I, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port STB_I, input, 1 bit: request strobe from the upstream controller.
REQ-009 SHALL have port DAT_I, input, 8 bits: byte to send.
REQ-010 SHALL have port RS_I, input, 1 bit: register select (0 = command, 1 = data).
REQ-011 SHALL have port NYB_I, input, 1 bit: send DAT_I[7:4] only, for init sequences.
REQ-012 SHALL have port ACK_O, output, 1 bit: one-cycle accept pulse.
REQ-013 SHALL have port BUSY_O, output, 1 bit: transfer or wait in progress.
REQ-014 SHALL have port LCD_E, output, 1 bit: HD44780 enable.
REQ-015 SHALL have port LCD_RS, output, 1 bit: HD44780 register select.
REQ-016 SHALL have port LCD_RW, output, 1 bit: HD44780 read/write, constant 0 (write only).
REQ-017 SHALL have port LCD_D, output, 4 bits: HD44780 DB7..DB4.

Function
REQ-018 SHALL implement states IDLE, HI_SETUP, HI_E, HI_GAP, LO_SETUP, LO_E, LO_GAP and WAIT, with a single down-counter wide enough for LONG_WAIT_CYCLES.
REQ-019 SHALL, in IDLE with STB_I=1 at an edge, latch DAT_I, RS_I and NYB_I, and enter HI_SETUP.
REQ-020 SHALL, on that acceptance, drive ACK_O=1 and BUSY_O=1 in the next cycle; ACK_O is high for exactly 1 cycle.
REQ-021 SHALL ignore STB_I while BUSY_O=1: no ACK_O, no latch, no queueing; the upstream block must hold or re-issue the request.
REQ-022 SHALL drive LCD_RS and LCD_D (the latched [7:4]) from the first HI_SETUP cycle, held until LO_SETUP.
REQ-023 SHALL make the state durations exact cycle counts: HI_SETUP = SETUP_CYCLES, HI_E = E_PULSE_CYCLES with LCD_E=1, HI_GAP = GAP_CYCLES with LCD_E=0.
REQ-024 SHALL, in LO_SETUP, switch LCD_D to latched [3:0], then run LO_E and LO_GAP with the same durations as the high phase.
REQ-025 SHALL, when NYB=1, skip the LO_* states: HI_GAP goes directly to WAIT.
REQ-026 SHALL choose the wait length as follows: LONG_WAIT_CYCLES if latched RS=0, NYB=0 and byte is 0x01, 0x02 or 0x03; otherwise CMD_WAIT_CYCLES.
REQ-027 SHALL keep LCD_RS/LCD_D unchanged during WAIT, then return to IDLE.
REQ-028 SHALL drop BUSY_O in the first IDLE cycle; a STB_I held high is accepted at that edge.
REQ-029 SHALL give BUSY_O high for exactly 2*(SETUP+E_PULSE+GAP)+wait cycles for a byte, and SETUP+E_PULSE+GAP+wait for a nybble.
REQ-030 SHALL register all outputs (no combinational paths from inputs to outputs); LCD_E never glitches.

Reset
REQ-031 SHALL, with RST_I=1 at an edge, go to IDLE and zero the counter; next cycle ACK_O=0, BUSY_O=0, LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_D=4'h0.
REQ-032 SHALL abort any transfer or wait on reset mid-operation, with LCD_E low from the next cycle; RST_I has priority over a simultaneous STB_I.

Verification (SETUP=2, E_PULSE=4, GAP=6, CMD_WAIT=20, LONG_WAIT=100)
REQ-033 SHALL verify the data byte case: RS_I=1, DAT_I=0x48, 1-cycle STB_I -> ACK_O single pulse; LCD_D=0x4 with E high 4 cycles after 2 setup cycles; then LCD_D=0x8 with the same timing; BUSY_O high exactly 44 cycles.
REQ-034 SHALL verify the clear case: RS_I=0, DAT_I=0x01 -> LCD_RS=0, nybbles 0x0 then 0x1; BUSY_O high exactly 124 cycles.
REQ-035 SHALL verify the nybble case: NYB_I=1, DAT_I=0x30 -> one E pulse with LCD_D=0x3; BUSY_O high exactly 32 cycles.
REQ-036 SHALL verify busy and back-to-back behaviour: STB_I pulsed mid-transfer -> no ACK_O and outputs unaffected; STB_I held high across transfers -> second ACK_O occurs exactly in the cycle after BUSY_O first reads 0.
REQ-037 SHALL verify reset mid-operation: RST_I asserted during HI_E -> next cycle LCD_E=0, BUSY_O=0, LCD_D=0; a subsequent STB_I is accepted normally.
REQ-038 SHALL verify reset priority: RST_I and STB_I both high in IDLE -> no ACK_O and BUSY_O stays 0.
